// File: rtl/pueo_stream_pkg.sv
// rtl/pueo_stream_pkg.sv - shared sample widths, packing helpers and player state type
package pueo_stream_pkg;

  localparam int NSAMP    = 8;
  localparam int NBITS    = 12;
  localparam int PACKBITS = 16;
  localparam int RAWW     = NSAMP * NBITS;
  localparam int PKW      = NSAMP * PACKBITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } player_state_t;

  // Each 12-bit sample lands in the top of its 16-bit lane; low nibble is zero.
  function automatic logic [PKW-1:0] pack96to128(input logic [RAWW-1:0] raw);
    logic [PKW-1:0] p;
    p = '0;
    for (int i = 0; i < NSAMP; i++) begin
      p[PACKBITS*i + (PACKBITS-NBITS) +: NBITS] = raw[NBITS*i +: NBITS];
    end
    return p;
  endfunction

  function automatic logic [RAWW-1:0] unpack128to96(input logic [PKW-1:0] p);
    logic [RAWW-1:0] raw;
    raw = '0;
    for (int i = 0; i < NSAMP; i++) begin
      raw[NBITS*i +: NBITS] = p[PACKBITS*i + (PACKBITS-NBITS) +: NBITS];
    end
    return raw;
  endfunction

endpackage

// File: rtl/axis_sample_player_if.sv
// rtl/axis_sample_player_if.sv - packed sample stream bundle
interface axis_sample_player_if;
  import pueo_stream_pkg::*;

  logic [PKW-1:0] tdata;
  logic           tvalid;
  logic           tready;
  logic           tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_player_obuf.sv
// rtl/axis_player_obuf.sv - 2-entry output FIFO with flush that keeps the presented beat
module axis_player_obuf
  import pueo_stream_pkg::*;
(
  input  logic           aclk,
  input  logic           aresetn,
  input  logic           push_i,
  input  logic [PKW-1:0] push_data_i,
  input  logic           push_last_i,
  input  logic           flush_i,
  input  logic           tready_i,
  output logic [PKW-1:0] tdata_o,
  output logic           tvalid_o,
  output logic           tlast_o,
  output logic [1:0]     count_o
);

  logic [PKW-1:0] head_data_q, tail_data_q;
  logic           head_last_q, tail_last_q;
  logic           head_vld_q, tail_vld_q;
  logic           pop;
  logic           head_free;

  assign pop       = head_vld_q && tready_i;
  assign head_free = !head_vld_q || pop;

  // Head is the presented beat and never changes while it waits for tready;
  // the caller only pushes when an entry will be free at this edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      head_data_q <= '0;
      head_last_q <= 1'b0;
      head_vld_q  <= 1'b0;
      tail_data_q <= '0;
      tail_last_q <= 1'b0;
      tail_vld_q  <= 1'b0;
    end else if (flush_i) begin
      tail_vld_q <= 1'b0;
      if (pop) begin
        head_vld_q <= 1'b0;
      end
    end else if (head_free) begin
      if (tail_vld_q) begin
        head_data_q <= tail_data_q;
        head_last_q <= tail_last_q;
        head_vld_q  <= 1'b1;
        tail_data_q <= push_data_i;
        tail_last_q <= push_last_i;
        tail_vld_q  <= push_i;
      end else begin
        head_data_q <= push_data_i;
        head_last_q <= push_last_i;
        head_vld_q  <= push_i;
      end
    end else if (push_i) begin
      tail_data_q <= push_data_i;
      tail_last_q <= push_last_i;
      tail_vld_q  <= 1'b1;
    end
  end

  assign tdata_o  = head_data_q;
  assign tvalid_o = head_vld_q;
  assign tlast_o  = head_last_q;
  assign count_o  = {1'b0, head_vld_q} + {1'b0, tail_vld_q};

endmodule

// File: rtl/axis_sample_player.sv
// rtl/axis_sample_player.sv - plays a stored 96-bit sample record out as a packed 128-bit stream
module axis_sample_player
  import pueo_stream_pkg::*;
#(
  parameter int ADDRBITS = 10
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                wr_en_i,
  input  logic [ADDRBITS-1:0] wr_addr_i,
  input  logic [RAWW-1:0]     wr_data_i,
  input  logic [ADDRBITS:0]   len_i,
  input  logic                loop_i,
  input  logic                start_i,
  input  logic                stop_i,
  axis_sample_player_if.master play,
  output logic                busy_o,
  output logic                done_o
);

  localparam int              DEPTH    = 2 ** ADDRBITS;
  localparam logic [ADDRBITS:0] FULL_LEN = (ADDRBITS + 1)'(DEPTH);

  logic [RAWW-1:0]     mem_q [DEPTH];
  player_state_t       state_q;
  logic [ADDRBITS-1:0] addr_q;
  logic [ADDRBITS:0]   len_q;
  logic                loop_q;
  logic                done_q;

  logic                rd_issue;
  logic                rd_last;
  logic                flush;
  logic [1:0]          ob_count;
  logic [PKW-1:0]      ob_tdata;
  logic                ob_tvalid;
  logic                ob_tlast;

  // Record write port; open in every state, contents survive reset.
  always_ff @(posedge aclk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // A read lands in the output FIFO at the next edge, so the FIFO's own
  // occupancy is the only credit that matters when deciding to read.
  assign rd_issue = (state_q == RUN) && !stop_i && (ob_count < 2'd2);
  assign rd_last  = ({1'b0, addr_q} == (len_q - 1'b1));
  assign flush    = (state_q == RUN) && stop_i;

  // Playback sequencer: latches the pass, walks the address, drains and signals done.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i && !stop_i) begin
            if (len_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= RUN;
              addr_q  <= '0;
              len_q   <= (len_i > FULL_LEN) ? FULL_LEN : len_i;
              loop_q  <= loop_i;
            end
          end
        end
        RUN: begin
          if (stop_i) begin
            state_q <= DRAIN;
          end else if (rd_issue) begin
            if (rd_last) begin
              addr_q <= '0;
              if (!loop_q) begin
                state_q <= DRAIN;
              end
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (ob_count == 2'd0) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  axis_player_obuf u_obuf (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .push_i      (rd_issue),
    .push_data_i (pack96to128(mem_q[addr_q])),
    .push_last_i (rd_last),
    .flush_i     (flush),
    .tready_i    (play.tready),
    .tdata_o     (ob_tdata),
    .tvalid_o    (ob_tvalid),
    .tlast_o     (ob_tlast),
    .count_o     (ob_count)
  );

  assign play.tdata  = ob_tdata;
  assign play.tvalid = ob_tvalid;
  assign play.tlast  = ob_tlast;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;

endmodule

// File: tb/tb_axis_sample_player.sv
// tb/tb_axis_sample_player.sv - directed bench for axis_sample_player
module tb_axis_sample_player;

  logic         aclk;
  logic         aresetn;
  logic         wr_en_i;
  logic [9:0]   wr_addr_i;
  logic [95:0]  wr_data_i;
  logic [10:0]  len_i;
  logic         loop_i;
  logic         start_i;
  logic         stop_i;
  logic         busy_o;
  logic         done_o;

  axis_sample_player_if play ();

  axis_sample_player #(.ADDRBITS(10)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .len_i     (len_i),
    .loop_i    (loop_i),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .play      (play),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  int tests = 0;
  int fails = 0;

  logic [127:0] q_data [$];
  logic         q_last [$];

  logic         hold_v = 1'b0;
  logic [127:0] hold_d;
  logic         hold_l;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  function automatic logic [95:0] raw_word(input int a);
    logic [95:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[12*k +: 12] = 12'(16*a + k);
    return r;
  endfunction

  function automatic logic [127:0] exp_word(input int a);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[16*k+4 +: 12] = 12'(16*a + k);
    return r;
  endfunction

  task automatic run_until_done(input int max, input bit toggle, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      step(1);
      if (done_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (toggle) play.tready = !play.tready;
    end
  endtask

  task automatic start_pass(input int len, input bit lp);
    len_i   = 11'(len);
    loop_i  = lp;
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
  endtask

  // Stream monitor: records accepted beats and checks stability of stalled beats.
  always @(negedge aclk) begin
    if (!aresetn) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_tvalid", play.tvalid, 1'b1);
        check("hold_tdata", play.tdata, hold_d);
        check("hold_tlast", play.tlast, hold_l);
      end
      if (play.tvalid && play.tready) begin
        q_data.push_back(play.tdata);
        q_last.push_back(play.tlast);
      end
      hold_v = play.tvalid && !play.tready;
      hold_d = play.tdata;
      hold_l = play.tlast;
    end
  end

  initial begin
    bit seen;
    int nlast;
    logic [95:0] odd_raw;

    aresetn = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    len_i = '0; loop_i = 1'b0; start_i = 1'b0; stop_i = 1'b0;
    play.tready = 1'b1;
    step(2);
    check("rst_tvalid", play.tvalid, 1'b0);
    check("rst_tlast", play.tlast, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    aresetn = 1'b1;
    step(1);

    for (int a = 0; a < 6; a++) begin
      wr_en_i = 1'b1; wr_addr_i = 10'(a); wr_data_i = raw_word(a);
      step(1);
    end
    wr_en_i = 1'b0;

    // one-shot, len=4, tready=1: beats on cycles 2..5, done on cycle 7
    q_data.delete(); q_last.delete();
    start_pass(4, 1'b0);
    check("t1_busy_c1", busy_o, 1'b1);
    check("t1_tvalid_c1", play.tvalid, 1'b0);
    step(1);
    check("t1_beat0_full", play.tdata, 128'h0070_0060_0050_0040_0030_0020_0010_0000);
    check("t1_beat0_s1", play.tdata[20 +: 12], 12'h001);
    for (int c = 2; c <= 5; c++) begin
      check("t1_tvalid_run", play.tvalid, 1'b1);
      step(1);
    end
    check("t1_tvalid_c6", play.tvalid, 1'b0);
    check("t1_done_c6", done_o, 1'b0);
    step(1);
    check("t1_done_c7", done_o, 1'b1);
    check("t1_busy_c7", busy_o, 1'b0);
    step(1);
    check("t1_done_c8", done_o, 1'b0);
    check("t1_count", q_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("t1_data", q_data[i], exp_word(i));
      check("t1_last", q_last[i], i == 3);
    end

    // same record with tready toggling
    q_data.delete(); q_last.delete();
    play.tready = 1'b1;
    start_pass(4, 1'b0);
    run_until_done(40, 1'b1, seen);
    play.tready = 1'b1;
    check("t2_done_seen", seen, 1'b1);
    check("t2_count", q_data.size(), 4);
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      check("t2_data", q_data[i], exp_word(i));
      check("t2_last", q_last[i], i == 3);
    end
    step(1);

    // looped len=3, stop after 10 accepted beats; presented beat still delivered
    q_data.delete(); q_last.delete();
    start_pass(3, 1'b1);
    for (int i = 0; i < 60; i++) begin
      if (q_data.size() >= 10) break;
      step(1);
    end
    check("t3_ten_beats", q_data.size(), 10);
    stop_i = 1'b1; play.tready = 1'b0;
    step(1);
    stop_i = 1'b0;
    check("t3_held_tvalid", play.tvalid, 1'b1);
    check("t3_held_data", play.tdata, exp_word(1));
    check("t3_busy_drain", busy_o, 1'b1);
    step(1);
    play.tready = 1'b1;
    run_until_done(20, 1'b0, seen);
    check("t3_done_seen", seen, 1'b1);
    check("t3_count", q_data.size(), 11);
    for (int i = 0; i < 11 && i < q_data.size(); i++) begin
      check("t3_data", q_data[i], exp_word(i % 3));
      check("t3_last", q_last[i], (i % 3) == 2);
    end
    step(1);

    // sink stalled from the start, stop while beat 0 is presented
    q_data.delete(); q_last.delete();
    play.tready = 1'b0;
    start_pass(4, 1'b0);
    step(3);
    stop_i = 1'b1;
    step(1);
    stop_i = 1'b0;
    check("t4_hold_c5", play.tdata, exp_word(0));
    step(1);
    check("t4_tvalid_c6", play.tvalid, 1'b1);
    check("t4_busy_c6", busy_o, 1'b1);
    play.tready = 1'b1;
    step(1);
    check("t4_tvalid_c7", play.tvalid, 1'b0);
    step(1);
    check("t4_done_c8", done_o, 1'b1);
    check("t4_count", q_data.size(), 1);
    check("t4_data", q_data[0], exp_word(0));

    // asynchronous reset mid-run, then replay from word 0
    play.tready = 1'b1;
    start_pass(4, 1'b1);
    step(2);
    check("t5_tvalid_pre", play.tvalid, 1'b1);
    aresetn = 1'b0;
    #1;
    check("t5_tvalid_rst", play.tvalid, 1'b0);
    check("t5_busy_rst", busy_o, 1'b0);
    step(2);
    aresetn = 1'b1;
    step(1);
    q_data.delete(); q_last.delete();
    start_pass(2, 1'b0);
    run_until_done(20, 1'b0, seen);
    check("t5_done_seen", seen, 1'b1);
    check("t5_count", q_data.size(), 2);
    check("t5_data0", q_data[0], exp_word(0));
    check("t5_data1", q_data[1], exp_word(1));
    check("t5_last1", q_last[1], 1'b1);
    step(1);

    // len=0 start, start+stop together, start while busy
    q_data.delete(); q_last.delete();
    start_pass(0, 1'b0);
    check("t6_len0_done", done_o, 1'b1);
    check("t6_len0_busy", busy_o, 1'b0);
    check("t6_len0_tvalid", play.tvalid, 1'b0);
    step(1);
    check("t6_len0_done_off", done_o, 1'b0);
    start_i = 1'b1; stop_i = 1'b1; len_i = 11'd4;
    step(1);
    start_i = 1'b0; stop_i = 1'b0;
    check("t6_startstop_busy", busy_o, 1'b0);
    step(1);
    check("t6_startstop_done", done_o, 1'b0);
    start_pass(4, 1'b0);
    step(1);
    start_i = 1'b1; len_i = 11'd2;
    step(1);
    start_i = 1'b0;
    run_until_done(20, 1'b0, seen);
    check("t6_busy_done_seen", seen, 1'b1);
    check("t6_busy_count", q_data.size(), 4);
    step(2);
    check("t6_no_restart", busy_o, 1'b0);

    // len=1 with extreme sample values: pure bit placement
    odd_raw = {12'h7FF, 12'h001, 12'h000, 12'hABC, 12'h123, 12'h800, 12'hFFF, 12'h800};
    wr_en_i = 1'b1; wr_addr_i = 10'd0; wr_data_i = odd_raw;
    step(1);
    wr_en_i = 1'b0;
    q_data.delete(); q_last.delete();
    start_pass(1, 1'b0);
    run_until_done(20, 1'b0, seen);
    check("t7_done_seen", seen, 1'b1);
    check("t7_count", q_data.size(), 1);
    check("t7_data", q_data[0], 128'h7FF0_0010_0000_ABC0_1230_8000_FFF0_8000);
    check("t7_last", q_last[0], 1'b1);
    step(1);

    // oversized length saturates to the full 1024-word record
    q_data.delete(); q_last.delete();
    start_pass(2047, 1'b0);
    run_until_done(1200, 1'b0, seen);
    check("t8_done_seen", seen, 1'b1);
    check("t8_count", q_data.size(), 1024);
    nlast = 0;
    foreach (q_last[i]) if (q_last[i] === 1'b1) nlast++;
    check("t8_nlast", nlast, 1);
    check("t8_last_final", q_last[q_last.size()-1], 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
